// File: rtl/mux_pkg.sv
// Shared definitions for the registered scanning multiplexer: mode encodings,
// controller state encodings and an elaboration-time ceiling-log2 helper.
// Contents: MODE_MANUAL/MODE_SCAN, state_t {IDLE, MANUAL, SCAN}, clog2().
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1, so single-value counters still get one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Combinational rotating priority finder: next set mask bit strictly after cur,
// searched cyclically (cur itself is the last candidate). Zero latency.
// Ports: mask/cur in; next_ch, wrapped (next_ch <= cur), none (mask empty) out.
module mux_next_ch #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    next_ch,
    output logic                wrapped,
    output logic                none
);

    int   idx;
    logic found;

    always_comb begin
        next_ch = cur;
        wrapped = 1'b0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = int'(cur) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!found && mask[SEL_W'(idx)]) begin
                found   = 1'b1;
                next_ch = SEL_W'(idx);
                wrapped = (idx <= int'(cur));
            end
        end
        none = ~|mask;
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 mux with manual select and a round-robin scan sequencer (DWELL cycles/channel).
// Latency: 1 cycle from sel (manual) or ptr (scan) to y; scan entry costs one cycle with y_valid=0.
// Ports: en/mode/sel/mask/d in; y, y_ch, y_valid, wrap (1-cycle pulse on pointer wrap) out.
module mux_scan_n
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 2,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       mask,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_valid,
    output logic                      wrap
);

    localparam int DCNT_W = clog2(DWELL);

    state_t              state_q,   state_d;
    logic [SEL_W-1:0]    ptr_q,     ptr_d;
    logic [DCNT_W-1:0]   dcnt_q,    dcnt_d;
    logic [WIDTH-1:0]    y_q,       y_d;
    logic [SEL_W-1:0]    y_ch_q,    y_ch_d;
    logic                y_valid_q, y_valid_d;
    logic                wrap_q,    wrap_d;

    logic [SEL_W-1:0]    step_ch;
    logic                step_wrapped;
    logic                step_none;
    logic [SEL_W-1:0]    first_ch;
    logic                first_wrapped;
    logic                first_none;

    // Advance search from the live pointer.
    mux_next_ch #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_step (
        .mask    (mask),
        .cur     (ptr_q),
        .next_ch (step_ch),
        .wrapped (step_wrapped),
        .none    (step_none)
    );

    // Starting from the top channel makes the cyclic search return the lowest set bit.
    mux_next_ch #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_first (
        .mask    (mask),
        .cur     (SEL_W'(CHANNELS - 1)),
        .next_ch (first_ch),
        .wrapped (first_wrapped),
        .none    (first_none)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dcnt_d    = dcnt_q;
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        y_valid_d = 1'b0;
        wrap_d    = 1'b0;

        if (!en) begin
            state_d = IDLE;
        end else if (mode == MODE_MANUAL) begin
            state_d = MANUAL;
            if (int'(sel) < CHANNELS) begin
                y_d       = d[int'(sel)*WIDTH +: WIDTH];
                y_ch_d    = sel;
                y_valid_d = 1'b1;
            end else begin
                y_d = '0;
            end
        end else begin
            state_d = SCAN;
            if (state_q != SCAN) begin
                // Fresh entry: any earlier dwell is discarded.
                ptr_d  = first_none ? '0 : first_ch;
                dcnt_d = '0;
            end else if (step_none) begin
                // Nothing enabled: freeze the sequencer so a restored mask resumes here.
            end else if (!mask[ptr_q]) begin
                // Current channel was disabled mid-dwell: skip it without sampling.
                ptr_d  = step_ch;
                dcnt_d = '0;
                wrap_d = step_wrapped;
            end else begin
                y_d       = d[int'(ptr_q)*WIDTH +: WIDTH];
                y_ch_d    = ptr_q;
                y_valid_d = 1'b1;
                if (dcnt_q == DCNT_W'(DWELL - 1)) begin
                    ptr_d  = step_ch;
                    dcnt_d = '0;
                    wrap_d = step_wrapped;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            dcnt_q    <= '0;
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            dcnt_q    <= dcnt_d;
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            y_valid_q <= y_valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  mask;
    logic [31:0] d;
    logic [7:0]  y;
    logic [1:0]  y_ch;
    logic        y_valid;
    logic        wrap;

    // Second build with a non-power-of-two channel count for the out-of-range select case.
    logic        en5;
    logic [2:0]  sel5;
    logic [4:0]  mask5;
    logic [39:0] d5;
    logic [7:0]  y5;
    logic [2:0]  y_ch5;
    logic        y_valid5;
    logic        wrap5;

    int checks = 0;
    int errors = 0;

    logic [7:0] ty [9];
    logic [1:0] tc [9];
    logic       tw [9];

    always #5 clk = ~clk;

    mux_scan_n #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
        .mask    (mask),
        .d       (d),
        .y       (y),
        .y_ch    (y_ch),
        .y_valid (y_valid),
        .wrap    (wrap)
    );

    mux_scan_n #(.WIDTH(8), .CHANNELS(5), .DWELL(2)) u_dut5 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en5),
        .mode    (1'b0),
        .sel     (sel5),
        .mask    (mask5),
        .d       (d5),
        .y       (y5),
        .y_ch    (y_ch5),
        .y_valid (y_valid5),
        .wrap    (wrap5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_out(input string tag, input logic [7:0] ey, input logic [1:0] ech,
                            input logic ev, input logic ew);
        tick();
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".y_ch"}, 32'(y_ch), 32'(ech));
        chk({tag, ".y_valid"}, 32'(y_valid), 32'(ev));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    task automatic tick_vw(input string tag, input logic ev, input logic ew);
        tick();
        chk({tag, ".y_valid"}, 32'(y_valid), 32'(ev));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = 2'd0;
        mask  = 4'b0000;
        d     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        en5   = 1'b0;
        sel5  = 3'd0;
        mask5 = 5'b00000;
        d5    = {8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset state
        #2;
        chk("rst.y", 32'(y), 32'h0);
        chk("rst.y_ch", 32'(y_ch), 32'h0);
        chk("rst.y_valid", 32'(y_valid), 32'h0);
        chk("rst.wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual: each select lands one cycle later
        en = 1'b1; mode = 1'b0;
        sel = 2'd0; tick_out("man0", 8'hA0, 2'd0, 1'b1, 1'b0);
        sel = 2'd1; tick_out("man1", 8'hB1, 2'd1, 1'b1, 1'b0);
        sel = 2'd2; tick_out("man2", 8'hC2, 2'd2, 1'b1, 1'b0);
        sel = 2'd3; tick_out("man3", 8'hD3, 2'd3, 1'b1, 1'b0);

        // Scan, full mask: entry cycle holds y with y_valid low, then two cycles per channel
        mode = 1'b1; mask = 4'b1111;
        tick_out("full.entry", 8'hD3, 2'd3, 1'b0, 1'b0);
        ty = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2, 8'hC2, 8'hD3, 8'hD3, 8'hA0};
        tc = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        tw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            tick_out($sformatf("full%0d", i), ty[i], tc[i], 1'b1, tw[i]);
        end

        // Disable: y holds, y_valid drops
        en = 1'b0;
        tick_out("idle", 8'hA0, 2'd0, 1'b0, 1'b0);

        // Sparse mask 1010 from a fresh entry
        en = 1'b1; mode = 1'b1; mask = 4'b1010;
        tick_vw("sp.entry", 1'b0, 1'b0);
        tick_out("sp0", 8'hB1, 2'd1, 1'b1, 1'b0);
        tick_out("sp1", 8'hB1, 2'd1, 1'b1, 1'b0);
        tick_out("sp2", 8'hD3, 2'd3, 1'b1, 1'b0);
        tick_out("sp3", 8'hD3, 2'd3, 1'b1, 1'b1);
        tick_out("sp4", 8'hB1, 2'd1, 1'b1, 1'b0);

        // Single bit 0100 mid-dwell on channel 1: skip cycle, then C2 forever, wrap every 2
        mask = 4'b0100;
        tick_vw("one.skip", 1'b0, 1'b0);
        tick_out("one0", 8'hC2, 2'd2, 1'b1, 1'b0);
        tick_out("one1", 8'hC2, 2'd2, 1'b1, 1'b1);
        tick_out("one2", 8'hC2, 2'd2, 1'b1, 1'b0);
        tick_out("one3", 8'hC2, 2'd2, 1'b1, 1'b1);

        // Clear mask[ptr] mid-dwell: advance on the next edge
        mask = 4'b1111;
        tick_out("clr.pre", 8'hC2, 2'd2, 1'b1, 1'b0);
        mask = 4'b1011;
        tick_vw("clr.skip", 1'b0, 1'b0);
        tick_out("clr.next", 8'hD3, 2'd3, 1'b1, 1'b0);

        // Empty mask freezes ptr and dcnt; restoring resumes mid-dwell on channel 3
        mask = 4'b0000;
        tick_out("empty0", 8'hD3, 2'd3, 1'b0, 1'b0);
        tick_out("empty1", 8'hD3, 2'd3, 1'b0, 1'b0);
        mask = 4'b1111;
        tick_out("resume0", 8'hD3, 2'd3, 1'b1, 1'b1);
        tick_out("resume1", 8'hA0, 2'd0, 1'b1, 1'b0);

        // Scan -> manual -> scan restarts at the lowest set bit
        mode = 1'b0; sel = 2'd2;
        tick_out("sw.man", 8'hC2, 2'd2, 1'b1, 1'b0);
        mode = 1'b1; mask = 4'b1110;
        tick_out("sw.entry", 8'hC2, 2'd2, 1'b0, 1'b0);
        tick_out("sw.scan", 8'hB1, 2'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-scan, observed between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.y", 32'(y), 32'h0);
        chk("arst.y_ch", 32'(y_ch), 32'h0);
        chk("arst.y_valid", 32'(y_valid), 32'h0);
        chk("arst.wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;

        // Five-channel build: legal top channel, then an out-of-range select
        en5 = 1'b1; sel5 = 3'd4;
        tick();
        chk("c5.y", 32'(y5), 32'hE4);
        chk("c5.y_ch", 32'(y_ch5), 32'd4);
        chk("c5.y_valid", 32'(y_valid5), 32'd1);
        sel5 = 3'd5;
        tick();
        chk("c5bad.y", 32'(y5), 32'h0);
        chk("c5bad.y_ch", 32'(y_ch5), 32'd4);
        chk("c5bad.y_valid", 32'(y_valid5), 32'd0);
        chk("c5bad.wrap", 32'(wrap5), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
